sr_lifo: RTL and testbench
==========================

Name: sr_lifo

Overview:
- Hardware stack (LIFO) that executes the custom `lifo.push rs1` / `rd = lifo.pop()` instructions of the single-cycle sr_cpu.
- Sits beside the register file, downstream of decode. Push takes rs1 data from the register file; pop data feeds the writeback mux into rd.
- Pop data is combinational from the current top entry, so a pop instruction completes in its own cycle. Pointer and storage update on the clock edge.

Parameters:
- DATA_WIDTH, 32, width of each stack entry (matches the register file word).
- DEPTH, 8, number of entries; legal values 2..256, need not be a power of 2.
- CNT_W, $clog2(DEPTH+1), derived width of count; do not override.

Ports:
- clk  input  1  CPU clock (cpuClk domain).
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  push request, sampled on rising clk.
- push_data  input  DATA_WIDTH  value to push (rs1 read data).
- pop  input  1  pop request, sampled on rising clk.
- pop_data  output  DATA_WIDTH  current top entry, combinational.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- count  output  CNT_W  number of valid entries.
- ovf  output  1  sticky overflow flag (see Optional Feature).
- udf  output  1  sticky underflow flag (see Optional Feature).
- err_clr  input  1  synchronous clear of ovf/udf.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low, on rst_n.
- Storage: DEPTH x DATA_WIDTH register array mem[0..DEPTH-1] plus pointer count. The top entry is mem[count-1].
- While rst_n=0, asynchronously and without waiting for a clock edge: count=0, every mem entry=0, ovf=0, udf=0, empty=1, full=0, pop_data=0.
- Deasserting reset mid-operation discards all stacked data.
- pop_data = mem[count-1] when count>0, else 0. It is purely combinational with zero latency: valid in the same cycle pop is asserted.
- empty and full are decoded combinationally from count.
- Actions on each rising clk edge, with rst_n=1:
  - push only, count<DEPTH: mem[count] <= push_data; count <= count+1.
  - push only, count==DEPTH: write ignored; count unchanged; overflow event.
  - pop only, count>0: count <= count-1. The vacated entry is not cleared.
  - pop only, count==0: count unchanged; pop_data reads 0; underflow event.
  - push and pop, count>0 (full included): replace top. pop_data returns the old top that cycle; mem[count-1] <= push_data; count unchanged; no overflow.
  - push and pop, count==0: underflow event; push proceeds normally, so count becomes 1 and mem[0] = push_data.
  - neither: hold.
- count never wraps: it stays in 0..DEPTH under every stimulus.
- The single-cycle CPU never raises push and pop together. The replace behaviour above is still mandatory.

Optional Feature:
- Macro: SR_LIFO_STATUS_EN.
- Defined:
  - ovf is set on an overflow event; udf is set on an underflow event.
  - Both flags hold until err_clr=1 at a rising clk edge, which clears them.
  - If an event and err_clr coincide, the set wins.
  - Flags update one cycle after the event.
- Undefined:
  - ovf and udf are tied to 0; err_clr is ignored.
  - The stack data behaviour above is unchanged.

Test Plan:
- Push 0x11, 0x22, 0x33 on consecutive cycles, then pop three times:
  - pop_data reads 0x33, 0x22, 0x11 in the respective pop cycles.
  - count goes 1,2,3 then 2,1,0.
  - empty=1 at the end.
- Fill DEPTH=8 with 1..8, then push 0x99:
  - full=1, count=8, pop_data=8 (0x99 is dropped).
  - ovf=1 the next cycle (with macro).
  - The following pop returns 8, count=7, full=0.
- Pop on an empty stack:
  - pop_data=0, count stays 0.
  - udf=1 the next cycle (with macro).
  - err_clr pulse then clears udf; without the macro udf stays 0 throughout.
- Replace at count=2, top=0xAA: assert push(0x55) and pop together.
  - pop_data=0xAA in that cycle.
  - Next cycle count=2 and pop_data=0x55.
  - Repeat the same replace at count=DEPTH: ovf stays 0.
- Async reset mid-stream: with count=5, drive rst_n low between clock edges.
  - count=0, empty=1, pop_data=0 immediately, before the next clk edge.
  - After release, a pop returns 0 and flags underflow.
- Integration in sm_top: program pushes a0=7 then pops into x5.
  - The trace shows x5=7 on the pop instruction's writeback cycle.

Source files
------------

// File: rtl/sr_lifo.sv
// sr_lifo: hardware stack executing lifo.push / lifo.pop for the single-cycle sr_cpu.
// Pop data is read combinationally from the top entry, so a pop completes in its own cycle.
// Pointer and storage update on the rising clk edge.
// Optional feature: define SR_LIFO_STATUS_EN to enable the sticky ovf/udf status flags.
// Without the macro, ovf and udf are tied to 0 and err_clr is ignored.
module sr_lifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_W-1:0]      count,
  output logic                  ovf,
  output logic                  udf,
  input  logic                  err_clr
);

  localparam int               IDX_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0]      nextCnt;
  logic [IDX_W-1:0]      topIdx;
  logic [IDX_W-1:0]      wrIdx;
  logic                  wrEn;
  logic                  ovfEvt;
  logic                  udfEvt;

  assign empty  = (count == '0);
  assign full   = (count == DEPTH_C);
  assign topIdx = IDX_W'(count - ONE_C);

  // Top-of-stack read; an empty stack reads as zero.
  assign pop_data = empty ? '0 : mem[topIdx];

  // Decode the push/pop request against the current fill level.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    nextCnt = count;
    wrEn    = 1'b0;
    wrIdx   = '0;
    ovfEvt  = 1'b0;
    udfEvt  = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full) begin
          wrEn    = 1'b1;
          wrIdx   = IDX_W'(count);
          nextCnt = count + ONE_C;
        end else begin
          ovfEvt = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) begin
          nextCnt = count - ONE_C;
        end else begin
          udfEvt = 1'b1;
        end
      end
      2'b11: begin
        // Replace the top entry; an empty stack flags underflow and still takes the push.
        wrEn = 1'b1;
        if (!empty) begin
          wrIdx = topIdx;
        end else begin
          udfEvt  = 1'b1;
          wrIdx   = '0;
          nextCnt = ONE_C;
        end
      end
      default: ;
    endcase
  end

  // Stack pointer and storage; reset discards all stacked data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      // NOTE: the storage array is cleared on reset because pop_data and the data after a reset-then-push are observable; this costs a reset net per bit.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
      count <= nextCnt;
      if (wrEn) begin
        mem[wrIdx] <= push_data;
      end
    end
  end

`ifdef SR_LIFO_STATUS_EN
  // Sticky error flags: an event sets, err_clr clears, and set wins when both occur.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (ovfEvt) begin
        ovf <= 1'b1;
      end else if (err_clr) begin
        ovf <= 1'b0;
      end
      if (udfEvt) begin
        udf <= 1'b1;
      end else if (err_clr) begin
        udf <= 1'b0;
      end
    end
  end
`else
  // Status flags disabled: tie off and absorb the now-unused event terms.
  logic unusedStatus;
  assign unusedStatus = ^{err_clr, ovfEvt, udfEvt};
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_sr_lifo.sv
// tb_sr_lifo: directed stimulus for sr_lifo with a scoreboard queue of expected
// per-cycle observations and a monitor that compares them on the falling clk edge.
module tb_sr_lifo;

  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 8;
  localparam int CNT_W      = $clog2(DEPTH + 1);
`ifdef SR_LIFO_STATUS_EN
  localparam bit ST = 1'b1;
`else
  localparam bit ST = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] popData;
    int          cnt;
    logic        ovf;
    logic        udf;
  } exp_t;

  logic                  clk;
  logic                  rst_n;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  empty;
  logic                  full;
  logic [CNT_W-1:0]      count;
  logic                  ovf;
  logic                  udf;
  logic                  err_clr;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  sr_lifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .empty(empty), .full(full), .count(count),
    .ovf(ovf), .udf(udf), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Queue the expected observation for the current cycle.
  task automatic chk(input string name, input logic [31:0] pd, input int cnt,
                     input logic ov, input logic ud);
    exp_t e;
    e.name = name; e.popData = pd; e.cnt = cnt; e.ovf = ov; e.udf = ud;
    expQ.push_back(e);
  endtask

  // Drive inputs just after a rising edge; they are sampled on the next one.
  task automatic drive(input logic pu, input logic [31:0] d, input logic po, input logic ec);
    @(posedge clk);
    #1;
    push = pu; push_data = d; pop = po; err_clr = ec;
  endtask

  // Monitor: the DUT presents its outputs every cycle; compare any pending expectation.
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      check({e.name, ".pop_data"}, pop_data, e.popData);
      check({e.name, ".count"}, 32'(count), 32'(e.cnt));
      check({e.name, ".empty"}, 32'(empty), 32'(e.cnt == 0));
      check({e.name, ".full"}, 32'(full), 32'(e.cnt == DEPTH));
      check({e.name, ".ovf"}, 32'(ovf), 32'(e.ovf));
      check({e.name, ".udf"}, 32'(udf), 32'(e.udf));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; push = 1'b0; push_data = '0; pop = 1'b0; err_clr = 1'b0;
    chk("reset", 32'h0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Push three values then pop them back in reverse order.
    drive(1, 32'h11, 0, 0); chk("push11", 32'h0, 0, 0, 0);
    drive(1, 32'h22, 0, 0); chk("push22", 32'h11, 1, 0, 0);
    drive(1, 32'h33, 0, 0); chk("push33", 32'h22, 2, 0, 0);
    drive(0, 0, 1, 0);      chk("pop33", 32'h33, 3, 0, 0);
    drive(0, 0, 1, 0);      chk("pop22", 32'h22, 2, 0, 0);
    drive(0, 0, 1, 0);      chk("pop11", 32'h11, 1, 0, 0);
    drive(0, 0, 0, 0);      chk("drained", 32'h0, 0, 0, 0);

    // Fill with 1..8, then an overflowing push is dropped.
    for (int i = 1; i <= DEPTH; i++) drive(1, 32'(i), 0, 0);
    drive(1, 32'h99, 0, 0); chk("full_push99", 32'h8, 8, 0, 0);
    drive(0, 0, 1, 0);      chk("ovf_pop8", 32'h8, 8, ST, 0);
    drive(0, 0, 0, 0);      chk("after_pop8", 32'h7, 7, ST, 0);
    drive(0, 0, 0, 1);      chk("ovf_clr_req", 32'h7, 7, ST, 0);
    drive(0, 0, 0, 0);      chk("ovf_cleared", 32'h7, 7, 0, 0);
    for (int i = 0; i < DEPTH - 1; i++) drive(0, 0, 1, 0);

    // Underflow on an empty stack, sticky until err_clr, set wins over clear.
    drive(0, 0, 1, 0);      chk("udf_pop", 32'h0, 0, 0, 0);
    drive(0, 0, 0, 0);      chk("udf_set", 32'h0, 0, 0, ST);
    drive(0, 0, 0, 1);      chk("udf_sticky", 32'h0, 0, 0, ST);
    drive(0, 0, 1, 1);      chk("udf_cleared", 32'h0, 0, 0, 0);
    drive(0, 0, 0, 0);      chk("udf_set_wins", 32'h0, 0, 0, ST);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);      chk("udf_clear2", 32'h0, 0, 0, 0);

    // Replace the top at count 2, then check the entry below is intact.
    drive(1, 32'h01, 0, 0);
    drive(1, 32'hAA, 0, 0);
    drive(1, 32'h55, 1, 0); chk("repl_old", 32'hAA, 2, 0, 0);
    drive(0, 0, 1, 0);      chk("repl_new", 32'h55, 2, 0, 0);
    drive(0, 0, 0, 0);      chk("repl_below", 32'h01, 1, 0, 0);

    // Replace at full: no overflow.
    for (int i = 2; i <= DEPTH; i++) drive(1, 32'(i * 16), 0, 0);
    drive(1, 32'hCC, 1, 0); chk("repl_full_old", 32'h80, 8, 0, 0);
    drive(0, 0, 0, 0);      chk("repl_full_new", 32'hCC, 8, 0, 0);

    // Asynchronous reset with five entries stacked.
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);      chk("pre_rst", 32'h50, 5, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    chk("async_rst", 32'h0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, 1, 0);      chk("post_rst_pop", 32'h0, 0, 0, 0);
    drive(0, 0, 0, 0);      chk("post_rst_udf", 32'h0, 0, 0, ST);

    // Push and pop together on an empty stack: underflow, push still lands.
    drive(1, 32'h77, 1, 0); chk("pp_empty", 32'h0, 0, 0, ST);
    drive(0, 0, 0, 0);      chk("pp_empty_after", 32'h77, 1, 0, ST);

    repeat (3) @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
